// File: rtl/ctrl_pkg.sv
// Shared execution-control types: controller state encoding, opcodes and the datapath decode.
// Purely combinational helpers, no backpressure.
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_JUMP  = 2'b11;

  typedef struct packed {
    logic reg_dst;
    logic reg_write;
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic jump;
  } ctrl_t;

  // Only the opcode field selects controls; an unknown opcode yields all-zero controls.
  function automatic ctrl_t decode(input logic [1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      OP_LOAD:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; end
      OP_STORE: begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
      OP_JUMP:  c.jump = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler for RUN mode: counts 0..DIV-1 while enabled, tick is high combinationally on DIV-1.
// Zero-latency tick from the registered count; clear has priority over counting, no backpressure.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic _CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] count;

  always_ff @(posedge _CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? 8'd0 : count + 8'd1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/exec_controller.sv
// Run/step/halt execution controller with PC breakpoint, prescaled RUN and instruction decode.
// exec_en is registered (one cycle after the deciding edge); commands are pulses, no backpressure.
module exec_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic        _CLK,
  input  logic        RESET,
  input  logic        run,
  input  logic        step,
  input  logic        halt,
  input  logic        bp_en,
  input  logic [7:0]  bp_addr,
  input  logic [7:0]  PC,
  input  logic [7:0]  instruction,
  output logic        exec_en,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        jump,
  output logic [1:0]  state,
  output logic        halted,
  output logic [15:0] retired
);

  state_t state_q;
  state_t state_d;
  logic   exec_d;
  logic   leave_halt;
  logic   skip_bp;
  logic   tick;
  logic   tick_clear;
  logic   tick_enable;
  logic   bp_hit;
  ctrl_t  dec;
  logic   unused_instr_bits;

  assign tick_enable = (state_q == RUN);
  assign tick_clear  = (state_q != RUN) && (state_d == RUN);
  assign bp_hit      = bp_en && (PC == bp_addr) && !skip_bp;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    ._CLK   (_CLK),
    .RESET  (RESET),
    .clear  (tick_clear),
    .enable (tick_enable),
    .tick   (tick)
  );

  always_comb begin
    state_d    = state_q;
    exec_d     = 1'b0;
    leave_halt = 1'b0;
    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = HALT;
        end else if (step) begin
          state_d = STEP;
          exec_d  = 1'b1;
        end else if (run) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = HALT;
        end else if (tick) begin
          if (bp_hit) state_d = HALT;
          else        exec_d  = 1'b1;
        end
      end
      STEP: state_d = HALT;
      HALT: begin
        // halt wins over run/step, so a coincident halt keeps us parked
        if (!halt && step) begin
          state_d    = STEP;
          exec_d     = 1'b1;
          leave_halt = 1'b1;
        end else if (!halt && run) begin
          state_d    = RUN;
          leave_halt = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge _CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      exec_en <= 1'b0;
      skip_bp <= 1'b0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      exec_en <= exec_d;
      // resuming arms a one-shot bypass so the breakpoint instruction itself executes
      if (leave_halt)   skip_bp <= 1'b1;
      else if (exec_en) skip_bp <= 1'b0;
      if (exec_en && (retired != 16'hFFFF)) retired <= retired + 16'd1;
    end
  end

  assign state  = state_q;
  assign halted = (state_q == HALT);

  assign dec               = decode(instruction[7:6]);
  assign unused_instr_bits = ^instruction[5:0];

  assign reg_dst    = dec.reg_dst;
  assign reg_write  = dec.reg_write & exec_en;
  assign alu_src    = dec.alu_src;
  assign mem_read   = dec.mem_read;
  assign mem_write  = dec.mem_write & exec_en;
  assign mem_to_reg = dec.mem_to_reg;
  assign jump       = dec.jump;

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench for exec_controller with a small PC-advancing datapath model.
module tb_exec_controller;

  logic        _CLK;
  logic        RESET;
  logic        run, step, halt;
  logic        bp_en;
  logic [7:0]  bp_addr;
  logic [7:0]  PC;
  logic [7:0]  instruction;
  logic        exec_en;
  logic        reg_dst, reg_write, alu_src, mem_read, mem_write, mem_to_reg, jump;
  logic [1:0]  state;
  logic        halted;
  logic [15:0] retired;
  logic        pc_rst;

  int n_checks = 0;
  int n_fail   = 0;

  exec_controller #(.DIV(4)) dut (
    ._CLK        (_CLK),
    .RESET       (RESET),
    .run         (run),
    .step        (step),
    .halt        (halt),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .PC          (PC),
    .instruction (instruction),
    .exec_en     (exec_en),
    .reg_dst     (reg_dst),
    .reg_write   (reg_write),
    .alu_src     (alu_src),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .jump        (jump),
    .state       (state),
    .halted      (halted),
    .retired     (retired)
  );

  initial _CLK = 1'b0;
  always #5 _CLK = ~_CLK;

  // Datapath stand-in: commits on exec_en, loops 0..5 so PC 3 recurs
  always @(posedge _CLK) begin
    if (pc_rst)       PC <= 8'd0;
    else if (exec_en) PC <= (PC == 8'd5) ? 8'd0 : PC + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge _CLK);
    #1;
  endtask

  task automatic pulse(input logic r, input logic s, input logic h);
    run = r; step = s; halt = h;
    cyc(1);
    run = 1'b0; step = 1'b0; halt = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1; pc_rst = 1'b1;
    cyc(2);
    RESET = 1'b0; pc_rst = 1'b0;
  endtask

  task automatic wait_halted(input string tag, input int bound);
    int i;
    i = 0;
    while (!halted && i < bound) begin
      cyc(1);
      i++;
    end
    check(tag, 32'(halted), 32'd1);
  endtask

  initial begin
    logic [13:0] mask;
    int          n;
    run = 1'b0; step = 1'b0; halt = 1'b0;
    bp_en = 1'b0; bp_addr = 8'h00; instruction = 8'h00;
    RESET = 1'b1; pc_rst = 1'b1;

    do_reset();
    check("rst_state",   32'(state),   32'd0);
    check("rst_halted",  32'(halted),  32'd0);
    check("rst_exec_en", 32'(exec_en), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);

    // RUN cadence: exec_en at cycles 4, 8, 12 after entry
    pulse(1'b1, 1'b0, 1'b0);
    mask    = '0;
    mask[0] = exec_en;
    for (int c = 1; c < 14; c++) begin
      cyc(1);
      mask[c] = exec_en;
    end
    check("run_exec_pattern", 32'(mask),    32'h1110);
    check("run_retired",      32'(retired), 32'd3);
    check("run_state",        32'(state),   32'd1);
    pulse(1'b0, 1'b0, 1'b1);
    check("run_halt_state",  32'(state),  32'd3);
    check("run_halt_halted", 32'(halted), 32'd1);

    // single step from IDLE, then from HALT
    do_reset();
    pulse(1'b0, 1'b1, 1'b0);
    check("step1_state",   32'(state),   32'd2);
    check("step1_exec_en", 32'(exec_en), 32'd1);
    cyc(1);
    check("step1_after_state", 32'(state),   32'd3);
    check("step1_retired",     32'(retired), 32'd1);
    n = 0;
    repeat (3) begin
      cyc(1);
      n += int'(exec_en);
    end
    check("step1_no_extra_exec", 32'(n), 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    check("step2_exec_en", 32'(exec_en), 32'd1);
    cyc(1);
    check("step2_retired", 32'(retired), 32'd2);
    check("step2_state",   32'(state),   32'd3);

    // breakpoint at PC 3, resume executes it once, halts on next visit
    do_reset();
    bp_en = 1'b1; bp_addr = 8'h03;
    pulse(1'b1, 1'b0, 1'b0);
    wait_halted("bp_first_halt", 100);
    check("bp_first_pc",      32'(PC),      32'd3);
    check("bp_first_retired", 32'(retired), 32'd3);
    pulse(1'b1, 1'b0, 1'b0);
    check("bp_resume_state", 32'(state), 32'd1);
    wait_halted("bp_second_halt", 200);
    check("bp_second_pc",      32'(PC),      32'd3);
    check("bp_second_retired", 32'(retired), 32'd9);
    bp_en = 1'b0;

    // coincident run/step/halt from IDLE: halt wins
    do_reset();
    pulse(1'b1, 1'b1, 1'b1);
    check("all_cmd_state",   32'(state),   32'd3);
    check("all_cmd_exec_en", 32'(exec_en), 32'd0);
    cyc(1);
    check("all_cmd_exec_en2", 32'(exec_en), 32'd0);
    check("all_cmd_retired",  32'(retired), 32'd0);

    // decode and exec_en gating
    instruction = 8'b10110111;
    #1;
    check("store_idle_mem_write", 32'(mem_write), 32'd0);
    check("store_idle_alu_src",   32'(alu_src),   32'd1);
    check("store_idle_mem_read",  32'(mem_read),  32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    check("store_exec_mem_write", 32'(mem_write), 32'd1);
    check("store_exec_reg_write", 32'(reg_write), 32'd0);
    cyc(1);
    instruction = 8'b11xxxx10;
    pulse(1'b0, 1'b1, 1'b0);
    check("jump_jump",      32'(jump),      32'd1);
    check("jump_reg_write", 32'(reg_write), 32'd0);
    check("jump_exec_en",   32'(exec_en),   32'd1);
    cyc(1);
    instruction = 8'b00000000;
    pulse(1'b0, 1'b1, 1'b0);
    check("add_reg_write", 32'(reg_write), 32'd1);
    check("add_reg_dst",   32'(reg_dst),   32'd1);
    cyc(1);
    instruction = 8'b01000000;
    #1;
    check("load_gated_reg_write", 32'(reg_write),  32'd0);
    check("load_mem_read",        32'(mem_read),   32'd1);
    check("load_mem_to_reg",      32'(mem_to_reg), 32'd1);

    // reset lands exactly when the first RUN tick is due
    pulse(1'b1, 1'b0, 1'b0);
    cyc(3);
    RESET = 1'b1;
    cyc(1);
    check("rst_tick_exec_en", 32'(exec_en), 32'd0);
    check("rst_tick_state",   32'(state),   32'd0);
    check("rst_tick_retired", 32'(retired), 32'd0);
    RESET = 1'b0;
    cyc(1);
    check("rst_tick_exec_en2", 32'(exec_en), 32'd0);
    check("rst_tick_state2",   32'(state),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
